// File: rtl/morse_decoder_pkg.sv
// Shared constants and types for the morse decoder front end.
// Debounce defaults live here so the keyer and control paths agree on channel count and timing.
package morse_decoder_pkg;

  localparam int DEBOUNCE_NUM_CH_C      = 4;
  localparam int DEBOUNCE_THRESHOLD_C   = 20;
  localparam int LONG_PRESS_THRESHOLD_C = 1000;

  // Registered per-channel debounce state: accepted level plus its edge strobes.
  typedef struct packed {
    logic db;
    logic rise;
    logic fall;
  } db_status_t;

  function automatic db_status_t accept_level(input logic new_level);
    db_status_t s;
    s.db   = new_level;
    s.rise = new_level;
    s.fall = ~new_level;
    return s;
  endfunction

endpackage

// File: rtl/cdc.sv
// Two-flop level synchroniser for a bus of independent asynchronous bits.
// Each bit is synchronised on its own; no coherency between bits is implied.
module cdc #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] meta_q;
  logic [DATA_WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/debounce_channel.sv
// One debounce channel: tick-gated stability counter, accepted level and edge strobes.
// Optional hold counter (DEBOUNCE_LONG_PRESS_EN) emits a single long-press strobe per press.
module debounce_channel
  import morse_decoder_pkg::*;
#(
  parameter int THRESHOLD      = DEBOUNCE_THRESHOLD_C
`ifdef DEBOUNCE_LONG_PRESS_EN
  ,
  parameter int HOLD_THRESHOLD = LONG_PRESS_THRESHOLD_C
`endif
) (
  input  logic clk,
  input  logic resetn,
  input  logic tick_i,
  input  logic sync_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
`ifdef DEBOUNCE_LONG_PRESS_EN
  ,
  output logic long_o
`endif
);

  localparam int                CNT_W      = $clog2(THRESHOLD);
  localparam logic [CNT_W-1:0]  CNT_LAST_C = CNT_W'(THRESHOLD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  db_status_t       status_q, status_d;

  // A mismatch must persist for THRESHOLD ticks; any return to the accepted level restarts it.
  always_comb begin
    cnt_d         = cnt_q;
    status_d      = status_q;
    status_d.rise = 1'b0;
    status_d.fall = 1'b0;
    if (sync_i == status_q.db) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST_C) begin
        cnt_d    = '0;
        status_d = accept_level(sync_i);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q    <= '0;
      status_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  assign db_o   = status_q.db;
  assign rise_o = status_q.rise;
  assign fall_o = status_q.fall;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int                HOLD_W     = $clog2(HOLD_THRESHOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX_C = HOLD_W'(HOLD_THRESHOLD);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  // Saturation at HOLD_MAX_C is what limits the strobe to one per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!status_q.db) begin
      hold_d = '0;
    end else if (tick_i && (hold_q != HOLD_MAX_C)) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_q == (HOLD_MAX_C - 1'b1));
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: shared synchroniser feeding NUM_CH independent channels.
// Long-press strobes are built only when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_multi
  import morse_decoder_pkg::*;
#(
  parameter int NUM_CH         = DEBOUNCE_NUM_CH_C,
  parameter int THRESHOLD      = DEBOUNCE_THRESHOLD_C,
  parameter int HOLD_THRESHOLD = LONG_PRESS_THRESHOLD_C
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tick_i,
  input  logic [NUM_CH-1:0] raw_i,
  output logic [NUM_CH-1:0] db_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o
`ifdef DEBOUNCE_LONG_PRESS_EN
  ,
  output logic [NUM_CH-1:0] long_o
`endif
);

  // Reject configurations the counters cannot represent.
  if ((NUM_CH < 1) || (THRESHOLD < 2) || (HOLD_THRESHOLD <= THRESHOLD)) begin : g_bad_cfg
    $error("debounce_multi: illegal NUM_CH/THRESHOLD/HOLD_THRESHOLD combination");
  end

  logic [NUM_CH-1:0] sync;

  cdc #(
    .DATA_WIDTH(NUM_CH)
  ) u_cdc (
    .clk   (clk),
    .resetn(resetn),
    .d_i   (raw_i),
    .q_o   (sync)
  );

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_channel #(
      .THRESHOLD     (THRESHOLD)
`ifdef DEBOUNCE_LONG_PRESS_EN
      ,
      .HOLD_THRESHOLD(HOLD_THRESHOLD)
`endif
    ) u_channel (
      .clk   (clk),
      .resetn(resetn),
      .tick_i(tick_i),
      .sync_i(sync[ch]),
      .db_o  (db_o[ch]),
      .rise_o(rise_o[ch]),
      .fall_o(fall_o[ch])
`ifdef DEBOUNCE_LONG_PRESS_EN
      ,
      .long_o(long_o[ch])
`endif
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (NUM_CH=4, THRESHOLD=8, HOLD_THRESHOLD=32).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_debounce_multi;

  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              tick_i;
  logic [NUM_CH-1:0] raw_i;
  logic [NUM_CH-1:0] db_o;
  logic [NUM_CH-1:0] rise_o;
  logic [NUM_CH-1:0] fall_o;
`ifdef DEBOUNCE_LONG_PRESS_EN
  logic [NUM_CH-1:0] long_o;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int rise1_cnt = 0;
  int long0_cnt = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .NUM_CH        (NUM_CH),
    .THRESHOLD     (8),
    .HOLD_THRESHOLD(32)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .tick_i(tick_i),
    .raw_i (raw_i),
    .db_o  (db_o),
    .rise_o(rise_o),
    .fall_o(fall_o)
`ifdef DEBOUNCE_LONG_PRESS_EN
    ,
    .long_o(long_o)
`endif
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rise1_cnt += int'(rise_o[1]);
`ifdef DEBOUNCE_LONG_PRESS_EN
      long0_cnt += int'(long_o[0]);
`endif
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    resetn = 1'b0;
    tick_i = 1'b1;
    raw_i  = '0;
    step(2);
    check("reset_db", 32'(db_o), 32'h0);
    check("reset_rise", 32'(rise_o), 32'h0);
    check("reset_fall", 32'(fall_o), 32'h0);
    resetn = 1'b1;
    step(2);

    // Clean press on channel 0
    raw_i = 4'b0001;
    step(9);
    check("clean_db_before", 32'(db_o), 32'h0);
    step(1);
    check("clean_db", 32'(db_o), 32'h1);
    check("clean_rise", 32'(rise_o), 32'h1);
    step(1);
    check("clean_rise_one_cycle", 32'(rise_o), 32'h0);
    check("clean_db_held", 32'(db_o), 32'h1);
    raw_i = 4'b0000;
    step(10);
    check("clean_fall", 32'(fall_o), 32'h1);
    check("clean_db_release", 32'(db_o), 32'h0);
    step(2);

    // Bouncy press on channel 1
    rise1_cnt = 0;
    raw_i = 4'b0010;
    step(5);
    raw_i = 4'b0000;
    step(2);
    raw_i = 4'b0010;
    step(9);
    check("bounce_db_before", 32'(db_o), 32'h0);
    step(1);
    check("bounce_rise", 32'(rise_o), 32'h2);
    check("bounce_db", 32'(db_o), 32'h2);
    step(3);
    check("bounce_rise_count", 32'(rise1_cnt), 32'd1);
    raw_i = 4'b0000;
    step(12);
    check("bounce_db_release", 32'(db_o), 32'h0);

    // Tick gating on channel 2: ticks before edges 4, 8, ... 32
    raw_i = 4'b0100;
    for (int i = 1; i <= 32; i++) begin
      tick_i = ((i % 4) == 0);
      step(1);
      if (i == 31) check("tick_db_before", 32'(db_o), 32'h0);
    end
    check("tick_db", 32'(db_o), 32'h4);
    check("tick_rise", 32'(rise_o), 32'h4);
    tick_i = 1'b1;
    raw_i  = 4'b0000;
    step(12);
    check("tick_db_release", 32'(db_o), 32'h0);

    // Simultaneous events on all channels
    raw_i = 4'b1111;
    step(10);
    check("simul_rise", 32'(rise_o), 32'hF);
    check("simul_db", 32'(db_o), 32'hF);
    step(1);
    check("simul_rise_clear", 32'(rise_o), 32'h0);
    raw_i = 4'b0000;
    step(10);
    check("simul_fall", 32'(fall_o), 32'hF);
    check("simul_rise_excl", 32'(rise_o), 32'h0);
    check("simul_db_release", 32'(db_o), 32'h0);
    step(2);

    // Reset in the middle of a count
    raw_i = 4'b0001;
    step(5);
    resetn = 1'b0;
    step(1);
    check("midrst_db", 32'(db_o), 32'h0);
    check("midrst_strobes", 32'({rise_o, fall_o}), 32'h0);
    resetn = 1'b1;
    step(9);
    check("midrst_db_before", 32'(db_o), 32'h0);
    step(1);
    check("midrst_db", 32'(db_o), 32'h1);
    check("midrst_rise", 32'(rise_o), 32'h1);
    raw_i = 4'b0000;
    step(10);
    check("midrst_fall", 32'(fall_o), 32'h1);
    step(2);

`ifdef DEBOUNCE_LONG_PRESS_EN
    // Long press, re-arm, and short press on channel 0
    raw_i = 4'b0001;
    step(10);
    check("long_rise", 32'(rise_o), 32'h1);
    long0_cnt = 0;
    step(31);
    check("long_before", 32'(long_o), 32'h0);
    step(1);
    check("long_pulse", 32'(long_o), 32'h1);
    step(10);
    check("long_once", 32'(long0_cnt), 32'd1);
    raw_i = 4'b0000;
    step(10);
    check("long_release_fall", 32'(fall_o), 32'h1);
    raw_i = 4'b0001;
    step(10);
    check("long_rearm_rise", 32'(rise_o), 32'h1);
    step(32);
    check("long_rearm_pulse", 32'(long_o), 32'h1);
    raw_i = 4'b0000;
    step(12);
    long0_cnt = 0;
    raw_i = 4'b0001;
    step(10);
    check("short_rise", 32'(rise_o), 32'h1);
    step(10);
    raw_i = 4'b0000;
    step(10);
    check("short_fall", 32'(fall_o), 32'h1);
    step(5);
    check("short_no_long", 32'(long0_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Synchronises and debounces NUM_CH independent raw inputs (key, mode, reset buttons).
- Emits debounced levels plus one-cycle rise/fall strobes per channel.
- Counting is gated by an external tick strobe, so the shared prescaler sets the time base and counter widths stay small.
- Sits between board pins and the morse keyer/control FSMs.

Parameters:
- NUM_CH, 4: number of independent channels; at least 1.
- THRESHOLD, 20: consecutive ticks a changed level must persist before acceptance; at least 2.
- HOLD_THRESHOLD, 1000: ticks of continuous debounced-high before a long-press strobe; used only with the optional feature; greater than THRESHOLD.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- tick_i  in  1  time-base strobe, one clk wide; tie to 1 for per-cycle counting
- raw_i  in  NUM_CH  asynchronous raw button levels
- db_o  out  NUM_CH  debounced levels
- rise_o  out  NUM_CH  one-cycle strobe when db_o[n] goes 0->1
- fall_o  out  NUM_CH  one-cycle strobe when db_o[n] goes 1->0
- long_o  out  NUM_CH  one-cycle long-press strobe; only present when DEBOUNCE_LONG_PRESS_EN is defined

Behaviour:
- Reset (resetn=0 at a clk edge): db_o=0, rise_o=0, fall_o=0, long_o=0, all counters 0, synchroniser flops 0.
- Reset mid-count discards the partial count. Channels come out of reset treating 0 as the debounced state.
- Synchronisation: raw_i passes through a 2-flop cdc instance (DATA_WIDTH=NUM_CH) giving sync[n].
- Each channel is independent. No cross-channel interaction. Simultaneous events on different channels are all reported in the same cycle.
- Per-channel counter cnt is $clog2(THRESHOLD) bits wide.
- At each clk edge, per channel:
  - If sync == db: cnt <= 0. A glitch shorter than THRESHOLD ticks resets the count and produces no output change.
  - Else if tick_i=0: cnt holds.
  - Else if cnt == THRESHOLD-1: db <= sync, cnt <= 0, and the matching rise/fall strobe is asserted in the same cycle db_o changes.
  - Else: cnt <= cnt+1.
- Strobes: rise_o/fall_o are registered and high for exactly one clk, coincident with the first cycle of the new db_o value. rise_o[n] and fall_o[n] are never high together.
- Latency with tick_i tied 1: 2 cycles (synchroniser) + THRESHOLD cycles from a clean raw edge to the db_o change.
- Comparison uses the current sync value only; a bounce back resets cnt even if tick_i=0 that cycle.
- No wrap-around: cnt never exceeds THRESHOLD-1.

Optional Feature:
- Macro DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter, $clog2(HOLD_THRESHOLD+1) bits.
  - Cleared while db==0; increments on tick_i while db==1, saturating at HOLD_THRESHOLD.
  - long_o[n] pulses for one clk on the cycle the counter first reaches HOLD_THRESHOLD: at most one pulse per press.
  - Release clears the counter; the next press re-arms.
- Undefined: no hold counters; port long_o absent.

Decomposition:
- morse_decoder_pkg gains DEBOUNCE_NUM_CH_C, DEBOUNCE_THRESHOLD_C (reused as THRESHOLD default at top level) and LONG_PRESS_THRESHOLD_C.
- Sub-module debounce_channel: one channel's counter, db flop, strobes and optional hold counter.
- debounce_multi instantiates one shared cdc and a generate loop of NUM_CH debounce_channel instances.

Test Plan (NUM_CH=4, THRESHOLD=8, HOLD_THRESHOLD=32, tick_i=1 unless stated):
- Clean press: raw_i[0] 0->1 at cycle 0 and held -> db_o[0]=1 and rise_o[0]=1 (single cycle) at cycle 10; other channels stay 0.
- Bounce: raw_i[1] high for 5 cycles, low 2, then high and held -> no strobe until 8 stable synced cycles after the final rise; exactly one rise_o[1].
- Tick gating: tick_i pulses every 4th cycle, raw_i[2] held high -> db_o[2] rises 8 ticks (about 32 cycles + sync) later; no change while tick_i=0.
- Simultaneous: raw_i[3:0] 0000->1111 together -> rise_o=4'b1111 in one cycle; later release gives fall_o=4'b1111 in one cycle.
- Reset mid-count: raw_i[0] high for 5 cycles, then resetn=0 for 1 cycle -> db_o=0 and all strobes 0; acceptance needs a fresh 8-tick run after the synchroniser refills.
- Long press (macro defined): hold raw_i[0] -> long_o[0] pulses once 32 ticks after rise_o[0]; release then re-press -> a second pulse; a 20-tick press -> no pulse.
